// File: rtl/sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 for sizing counters; returns 1 for an argument of 2.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB-first over WIDTH cycles.
module bit_serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The partial difference is kept apart from diff_q so the visible result only changes on completion.
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    part_d       = part_q;
    diff_d       = diff_q;
    bin_d        = bin_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        part_d = part_q >> 1;
        part_d[WIDTH-2] = cell_d;
        bin_d  = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          diff_d       = {cell_d, part_q};
          borrow_out_d = cell_bout;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      part_q       <= '0;
      diff_q       <= '0;
      bin_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      part_q       <= part_d;
      diff_q       <= diff_d;
      bin_q        <= bin_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: doc/bit_serial_sub_ctrl.md
BIT_SERIAL_SUB_CTRL -- requirements
Module: bit_serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, requester presents operands.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, WIDTH, minuend, unsigned.
REQ-007 SHALL have port b, input, WIDTH, subtrahend, unsigned.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port diff, output, WIDTH, (a-b) mod 2^WIDTH.
REQ-011 SHALL have port borrow_out, output, 1, final borrow; 1 iff a<b.
REQ-012 SHALL have port busy, output, 1, high in RUN state.

Function
REQ-013 SHALL sequence one 1-bit full-subtractor cell over WIDTH cycles, LSB first; no parallel WIDTH-bit subtractor.
REQ-014 SHALL implement states IDLE, RUN, DONE; in_ready=1 only in IDLE, busy=1 only in RUN, out_valid=1 only in DONE.
REQ-015 IDLE: in_valid&in_ready at edge T -> capture a,b into shift registers, clear borrow register and bit counter, go RUN.
REQ-016 RUN, each cycle: cell computes d=a0^b0^bin, bout=(~a0&b0)|(~(a0^b0)&bin); d shifted into diff register from MSB side; operand registers shift right; bout registered as next bin; counter increments.
REQ-017 RUN -> DONE on the edge where counter==WIDTH-1; out_valid SHALL first be high exactly WIDTH cycles after acceptance edge T.
REQ-018 DONE: diff and borrow_out held stable until out_valid&out_ready; on that edge go IDLE.
REQ-019 diff and borrow_out SHALL retain last result in IDLE until the next completed operation overwrites them.
REQ-020 Changes on a, b, in_valid during RUN/DONE SHALL have no effect.
REQ-021 In DONE with out_ready and in_valid both high: result handed off, new operands NOT accepted that cycle; earliest acceptance is next cycle in IDLE (throughput one op per WIDTH+2 cycles).
REQ-022 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 Counter width SHALL be clog2(WIDTH); wrap-around never reached since RUN exits at WIDTH-1.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter=0, borrow register=0, operand and diff registers=0.
REQ-025 Under reset: in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result is ever presented.

Structure
REQ-027 State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 helper SHALL live in shared package sub_ctrl_pkg.
REQ-028 The bit cell SHALL be a separate sub-module full_subtractor_cell (a, b, bin -> d, bout), purely combinational; all state stays in bit_serial_sub_ctrl.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x23 accepted at T -> out_valid high at T+8, diff=0x37, borrow_out=0.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1 (borrow ripples all 8 bits).
REQ-031 a=b=0xA5, out_ready held low 5 cycles in DONE, in_valid pulsed with other operands -> diff=0x00, borrow_out=0 stable, in_ready=0, nothing accepted.
REQ-032 rst_n low during RUN cycle 4 -> outputs at reset values immediately; then a=0x10, b=0x01 -> diff=0x0F, borrow_out=0 after 8 cycles.
REQ-033 in_valid and out_ready held high, operands randomised every cycle during RUN -> each result matches operands sampled at acceptance; acceptances spaced exactly 10 cycles.
REQ-034 Random sweep, 1000 ops, random stalls on out_ready -> diff/borrow_out match (a-b) mod 256 and a<b for every handshake.
